// File: rtl/atm_disp_pkg.sv
// Shared constants for the ATM balance display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package atm_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_LET_E = 7'b0000110;
    localparam logic [6:0] SEG_LET_R = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        GL_DIGIT = 2'd0,
        GL_E     = 2'd1,
        GL_R     = 2'd2,
        GL_DASH  = 2'd3
    } glyph_e;

    // Non-decimal nibbles fall through to the dash glyph.
    function automatic logic [6:0] seg_digit(input logic [3:0] n);
        logic [6:0] p;
        p = SEG_DASH;
        case (n)
            4'd0: p = SEG_0;
            4'd1: p = SEG_1;
            4'd2: p = SEG_2;
            4'd3: p = SEG_3;
            4'd4: p = SEG_4;
            4'd5: p = SEG_5;
            4'd6: p = SEG_6;
            4'd7: p = SEG_7;
            4'd8: p = SEG_8;
            4'd9: p = SEG_9;
            default: p = SEG_DASH;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational glyph encoder: nibble/letter/dash/blank
// to an active-low seven-segment pattern.
import atm_disp_pkg::*;

module seg7_encode (
    input  logic [3:0] nibble,
    input  logic       blank,
    input  glyph_e     sel,
    output logic [6:0] pat
);

    always_comb begin
        pat = SEG_BLANK;
        if (!blank) begin
            unique case (sel)
                GL_DIGIT: pat = seg_digit(nibble);
                GL_E:     pat = SEG_LET_E;
                GL_R:     pat = SEG_LET_R;
                GL_DASH:  pat = SEG_DASH;
                default:  pat = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed seven-segment driver with per-frame
// snapshot, leading-zero blanking and anti-ghost blanking.
import atm_disp_pkg::*;

module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        res,
    input  logic [11:0] bcd,
    input  logic        err,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [11:0]   snap_bcd;
    logic          snap_err;
    logic          tick;

    logic [3:0]    hun;
    logic [3:0]    ten;
    logic [3:0]    one;
    logic [3:0]    nib;
    logic          blk;
    glyph_e        sel;
    logic [6:0]    pat;
    logic          guard;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;

    assign tick = (cnt == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (res) begin
            cnt      <= '0;
            idx      <= 2'd0;
            snap_bcd <= 12'h000;
            snap_err <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= idx + 2'd1;
            end
            // Capture only at the frame boundary so a frame is never mixed.
            if (tick && idx == 2'd3) begin
                snap_bcd <= bcd;
                snap_err <= err;
            end
        end
    end

    assign hun = snap_bcd[11:8];
    assign ten = snap_bcd[7:4];
    assign one = snap_bcd[3:0];

    always_comb begin
        nib = one;
        blk = 1'b0;
        sel = GL_DIGIT;
        unique case (idx)
            2'd3: blk = 1'b1;
            2'd2: begin
                nib = hun;
                sel = snap_err ? GL_E : GL_DIGIT;
                blk = !snap_err && hun == 4'd0;
            end
            2'd1: begin
                nib = ten;
                sel = snap_err ? GL_R : GL_DIGIT;
                blk = !snap_err && hun == 4'd0 && ten == 4'd0;
            end
            default: begin
                nib = one;
                sel = snap_err ? GL_R : GL_DIGIT;
            end
        endcase
    end

    seg7_encode u_enc (
        .nibble (nib),
        .blank  (blk),
        .sel    (sel),
        .pat    (pat)
    );

    assign guard   = (cnt < CW'(BLANK_CYC));
    assign an_nxt  = guard ? AN_OFF : ~(4'b0001 << idx);
    assign seg_nxt = guard ? SEG_BLANK : pat;

    always_ff @(posedge clk) begin
        if (res) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= 1'b1;
        end
    end

endmodule
